// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared tx state encoding and oversampling helper
package tx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_PRE   = 3'd1;
   localparam state_t ST_RUN   = 3'd2;
   localparam state_t ST_FLUSH = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Clocks per symbol for a given log2 oversampling factor
   function automatic int os_of(input int exp_os);
      return 1 << exp_os;
   endfunction

endpackage

// File: rtl/tx_burst_seq_if.sv
// rtl/tx_burst_seq_if.sv - command and tx timing bundle of the burst sequencer
interface tx_burst_seq_if #(
   parameter int EXP_OS = 2,
   parameter int LEN_W  = 16
);

   logic              i_start;
   logic              i_stop;
   logic [LEN_W-1:0]  i_burst_len;
   logic              o_busy;
   logic              o_done;
   logic              o_sym_valid;
   logic [EXP_OS-1:0] o_phase;
   logic              o_enb_filter;
   logic              o_zero_input;
   logic              o_preamble;
   logic [LEN_W-1:0]  o_sym_cnt;

   modport master (
      output i_start, i_stop, i_burst_len,
      input  o_busy, o_done, o_sym_valid, o_phase, o_enb_filter,
             o_zero_input, o_preamble, o_sym_cnt
   );

   modport slave (
      input  i_start, i_stop, i_burst_len,
      output o_busy, o_done, o_sym_valid, o_phase, o_enb_filter,
             o_zero_input, o_preamble, o_sym_cnt
   );

endinterface

// File: rtl/tx_burst_seq_sym_phase_cnt.sv
// rtl/tx_burst_seq_sym_phase_cnt.sv - oversampling phase counter with last-phase flag
module sym_phase_cnt
   import tx_pkg::*;
#(
   parameter int EXP_OS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   output logic [EXP_OS-1:0] o_phase,
   output logic              o_last
);

   localparam logic [EXP_OS-1:0] LAST_PHASE = EXP_OS'(os_of(EXP_OS) - 1);

   logic [EXP_OS-1:0] phase_q;
   logic [EXP_OS-1:0] phase_d;

   // Next phase: clear wins, otherwise advance and wrap naturally at OS-1
   always_comb begin
      phase_d = phase_q;
      if (i_clr) begin
         phase_d = '0;
      end else if (i_en) begin
         phase_d = phase_q + 1'b1;
      end
   end

   // Phase register
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign o_phase = phase_q;
   assign o_last  = (phase_q == LAST_PHASE);

endmodule

// File: rtl/tx_burst_seq.sv
// rtl/tx_burst_seq.sv - QPSK tx burst sequencer; optional preamble via TX_BURST_SEQ_PREAMBLE_EN
module tx_burst_seq
   import tx_pkg::*;
#(
   parameter int EXP_OS       = 2,
   parameter int LEN_W        = 16,
   parameter int FLUSH_SYM    = 6,
   parameter int PREAMBLE_LEN = 8
) (
   input  logic           clk,
   input  logic           rst,
   tx_burst_seq_if.slave  bus
);

   localparam int FLUSH_W = $clog2(FLUSH_SYM + 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_SYM - 1);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               stop_q, stop_d;
   logic [FLUSH_W-1:0] flush_q, flush_d;
`ifdef TX_BURST_SEQ_PREAMBLE_EN
   localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
   logic [PRE_W-1:0]   pre_q, pre_d;
`endif

   logic              busy;
   logic              start_ok;
   logic              stop_hit;
   logic [EXP_OS-1:0] phase;
   logic              last_phase;

   assign busy     = (state_q == ST_PRE) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign start_ok = (state_q == ST_IDLE) && bus.i_start && (bus.i_burst_len != '0);
   // A stop arriving on the boundary cycle itself still ends the burst at that boundary
   assign stop_hit = stop_q || bus.i_stop;

   sym_phase_cnt #(
      .EXP_OS (EXP_OS)
   ) u_phase (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (!busy),
      .i_en    (busy),
      .o_phase (phase),
      .o_last  (last_phase)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         stop_q  <= 1'b0;
         flush_q <= '0;
`ifdef TX_BURST_SEQ_PREAMBLE_EN
         pre_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         stop_q  <= stop_d;
         flush_q <= flush_d;
`ifdef TX_BURST_SEQ_PREAMBLE_EN
         pre_q   <= pre_d;
`endif
      end
   end

   // Next state; leaving PRE/RUN/FLUSH only happens on a symbol boundary
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
`ifdef TX_BURST_SEQ_PREAMBLE_EN
               state_d = ST_PRE;
`else
               state_d = ST_RUN;
`endif
            end
         end
`ifdef TX_BURST_SEQ_PREAMBLE_EN
         ST_PRE: begin
            if (last_phase) begin
               if (stop_hit) begin
                  state_d = ST_FLUSH;
               end else if (pre_q == PRE_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end
`endif
         ST_RUN: begin
            if (last_phase && (stop_hit || (cnt_q == len_q))) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (last_phase && (flush_q == FLUSH_LAST)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Burst length latch, payload/flush/preamble symbol counters and stop latch
   always_comb begin
      len_d   = start_ok ? bus.i_burst_len : len_q;
      cnt_d   = cnt_q;
      stop_d  = 1'b0;
      flush_d = '0;
      if (start_ok) begin
         cnt_d = '0;
      end else if ((state_q == ST_RUN) && (phase == '0)) begin
         cnt_d = cnt_q + 1'b1;
      end
      if ((state_q == ST_PRE) || (state_q == ST_RUN)) begin
         stop_d = stop_hit;
      end
      if (state_q == ST_FLUSH) begin
         flush_d = last_phase ? flush_q + 1'b1 : flush_q;
      end
`ifdef TX_BURST_SEQ_PREAMBLE_EN
      pre_d = '0;
      if (state_q == ST_PRE) begin
         pre_d = last_phase ? pre_q + 1'b1 : pre_q;
      end
`endif
   end

   // Moore outputs decoded from the registered state
   always_comb begin
      bus.o_busy       = busy;
      bus.o_done       = (state_q == ST_DONE);
      bus.o_sym_valid  = busy && (phase == '0);
      bus.o_phase      = phase;
      bus.o_enb_filter = busy;
      bus.o_zero_input = (state_q == ST_FLUSH);
`ifdef TX_BURST_SEQ_PREAMBLE_EN
      bus.o_preamble   = (state_q == ST_PRE);
`else
      bus.o_preamble   = 1'b0;
`endif
      bus.o_sym_cnt    = cnt_q;
   end

endmodule

// File: tb/tb_tx_burst_seq.sv
// tb/tb_tx_burst_seq.sv - randomized self-checking bench for tx_burst_seq
module tb_tx_burst_seq;

   localparam int EXP_OS       = 2;
   localparam int OS           = 4;
   localparam int LEN_W        = 16;
   localparam int FLUSH_SYM    = 6;
   localparam int PREAMBLE_LEN = 8;
`ifdef TX_BURST_SEQ_PREAMBLE_EN
   localparam int P_SYM = PREAMBLE_LEN;
`else
   localparam int P_SYM = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   tx_burst_seq_if #(.EXP_OS(EXP_OS), .LEN_W(LEN_W)) bus ();

   tx_burst_seq #(
      .EXP_OS       (EXP_OS),
      .LEN_W        (LEN_W),
      .FLUSH_SYM    (FLUSH_SYM),
      .PREAMBLE_LEN (PREAMBLE_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cur    = 0;

   // Burst descriptor: first busy cycle b, preamble symbols p, payload symbols n
   bit has_b  = 1'b0;
   int b      = 0;
   int p      = 0;
   int n      = 0;
   int prev_n = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", tag, cur, obs, exp);
      end
   endtask

   function automatic int end_cycle();
      return b + (p + n + FLUSH_SYM) * OS;
   endfunction

   function automatic bit model_idle();
      return !has_b || (cur < b) || (cur > end_cycle());
   endfunction

   task automatic compare_all();
      int e_busy, e_done, e_sv, e_ph, e_zero, e_pre, e_cnt;
      int off, poff;
      e_busy = 0; e_done = 0; e_sv = 0; e_ph = 0; e_zero = 0; e_pre = 0;
      e_cnt  = prev_n;
      if (has_b && cur >= b) begin
         e_cnt = n;
         off   = cur - b;
         if (cur < end_cycle()) begin
            e_busy = 1;
            e_ph   = off % OS;
            e_sv   = (e_ph == 0);
            e_pre  = ((off / OS) < p);
            e_zero = ((off / OS) >= p + n);
            poff   = off - p * OS;
            if (poff <= 0) e_cnt = 0;
            else e_cnt = ((poff + OS - 1) / OS < n) ? (poff + OS - 1) / OS : n;
         end else if (cur == end_cycle()) begin
            e_done = 1;
         end
      end
      check("busy",      32'(bus.o_busy),       32'(e_busy));
      check("done",      32'(bus.o_done),       32'(e_done));
      check("sym_valid", 32'(bus.o_sym_valid),  32'(e_sv));
      check("phase",     32'(bus.o_phase),      32'(e_ph));
      check("enb",       32'(bus.o_enb_filter), 32'(e_busy));
      check("zero",      32'(bus.o_zero_input), 32'(e_zero));
      check("preamble",  32'(bus.o_preamble),   32'(e_pre));
      check("sym_cnt",   32'(bus.o_sym_cnt),    32'(e_cnt));
   endtask

   task automatic model_apply(input bit st, input bit sp, input int ln, input bit r);
      int k;
      if (r) begin
         has_b  = 1'b0;
         prev_n = 0;
      end else if (model_idle()) begin
         if (st && ln != 0) begin
            prev_n = has_b ? n : prev_n;
            has_b  = 1'b1;
            b      = cur + 1;
            n      = ln;
            p      = P_SYM;
         end
      end else if (cur < end_cycle() && sp) begin
         k = (cur - b) / OS;
         if (k < p) begin
            p = k + 1;
            n = 0;
         end else if (k < p + n) begin
            n = (k - p + 1 < n) ? k - p + 1 : n;
         end
      end
   endtask

   task automatic cyc(input bit st, input bit sp, input int ln, input bit r);
      compare_all();
      bus.i_start     = st;
      bus.i_stop      = sp;
      bus.i_burst_len = ln[LEN_W-1:0];
      rst             = r;
      model_apply(st, sp, ln, r);
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic run_to_idle();
      int k;
      k = 0;
      while (!model_idle() && k < 5000) begin
         cyc(1'b0, 1'b0, 0, 1'b0);
         k++;
      end
   endtask

   bit st, sp, r;
   int ln;

   initial begin
      bus.i_start     = 1'b0;
      bus.i_stop      = 1'b0;
      bus.i_burst_len = '0;
      rst             = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cur = 0;

      // reset state, then a plain 4-symbol burst
      cyc(1'b0, 1'b0, 0, 1'b1);
      cyc(1'b0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b0, 4, 1'b0);
      run_to_idle();
      check("len4_cnt", 32'(bus.o_sym_cnt), 32'd4);

      // abort: stop six cycles after start
      cyc(1'b1, 1'b0, 100, 1'b0);
      repeat (5) cyc(1'b0, 1'b0, 0, 1'b0);
      cyc(1'b0, 1'b1, 0, 1'b0);
      run_to_idle();
      check("stop_cnt", 32'(bus.o_sym_cnt), 32'd2);

      // zero-length start ignored, start during run ignored
      cyc(1'b1, 1'b0, 0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check("len0_busy", 32'(bus.o_busy), 32'd0);
      cyc(1'b1, 1'b0, 5, 1'b0);
      repeat (6) cyc(1'b0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b0, 9, 1'b0);
      run_to_idle();
      check("run_start_cnt", 32'(bus.o_sym_cnt), 32'd5);

      // start and stop together in IDLE
      cyc(1'b1, 1'b1, 3, 1'b0);
      run_to_idle();
      check("start_stop_cnt", 32'(bus.o_sym_cnt), 32'd3);

      // start landing in the DONE cycle is ignored
      cyc(1'b1, 1'b0, 1, 1'b0);
      repeat ((P_SYM + 1 + FLUSH_SYM) * OS) cyc(1'b0, 1'b0, 0, 1'b0);
      check("done_pulse", 32'(bus.o_done), 32'd1);
      cyc(1'b1, 1'b0, 2, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check("done_start_busy", 32'(bus.o_busy), 32'd0);

      // reset held three cycles in the middle of a run
      cyc(1'b1, 1'b0, 50, 1'b0);
      repeat (40) cyc(1'b0, 1'b0, 0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 0, 1'b1);
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_cnt", 32'(bus.o_sym_cnt), 32'd0);
      repeat (60) cyc(1'b0, 1'b0, 0, 1'b0);

      // randomized bursts with stray starts, stops and resets
      for (int t = 0; t < 40; t++) begin
         ln = $urandom_range(1, 12);
         cyc(1'b1, ($urandom_range(0, 3) == 0), ln, 1'b0);
         for (int k = 0; k < 5000 && !model_idle(); k++) begin
            st = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cyc(st, sp, $urandom_range(0, 12), r);
         end
         repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 0, 1'b0);
         cyc(1'b1, 1'b0, 0, 1'b0);
      end
      cyc(1'b0, 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
